// File: rtl/glitch_sweep_sequencer.sv
// Fault-injection sweep sequencer: per attempt it holds the target in reset,
// waits a delay, fires a glitch pulse, watches the debug GPIOs for a success
// code and streams a 7-byte log record. Delay sweeps fastest, then length.
//
// Log stream handshake: a byte moves on every cycle where log_valid && log_ready.
// Once log_valid is high it stays high and log_data stays stable until that
// byte moves; only abort or RST can withdraw a pending byte.
module glitch_sweep_sequencer #(
    parameter logic [15:0] RESET_CYCLES   = 16'h200,
    parameter logic [15:0] DELAY_MIN      = 16'h001,
    parameter logic [15:0] DELAY_MAX      = 16'h300,
    parameter logic [15:0] LEN_MIN        = 16'h100,
    parameter logic [15:0] LEN_MAX        = 16'h180,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_000_000,
    parameter logic [7:0]  CODE_A         = 8'h88,
    parameter logic [7:0]  CODE_B         = 8'h25
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  debug_in,
    output logic        reset_out,
    output logic        glitch_out,
    output logic        busy,
    output logic        success,
    output logic        sweep_done,
    output logic [15:0] cur_delay,
    output logic [15:0] cur_len,
    output logic [15:0] attempt_count,
    output logic        log_valid,
    output logic [7:0]  log_data,
    input  logic        log_ready,
    output logic [2:0]  state_dbg
);
    typedef enum logic [2:0] {
        S_IDLE, S_RESET, S_DELAY, S_GLITCH, S_WATCH, S_LOG, S_ADVANCE, S_DONE
    } state_t;

    localparam logic [23:0] RESET_LAST   = {8'd0, RESET_CYCLES} - 24'd1;
    localparam logic [23:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 24'd1;

    state_t      state, state_n;
    logic [23:0] cnt, cnt_n;
    logic [15:0] delay_n, len_n, attempts_n;
    logic [7:0]  result, result_n;
    logic [2:0]  idx, idx_n;
    logic        valid_n, success_n, sweep_n;
    logic [7:0]  data_n;
    logic [7:0]  dbg_meta, dbg_sync;
    logic        code_hit;

    assign state_dbg = state;
    assign code_hit  = (dbg_sync == CODE_A) || (dbg_sync == CODE_B);

    function automatic logic [7:0] log_byte(input logic [2:0] i, input logic [15:0] d,
                                            input logic [15:0] l, input logic [7:0] r);
        case (i)
            3'd0:    log_byte = 8'h55;
            3'd1:    log_byte = 8'hAA;
            3'd2:    log_byte = d[15:8];
            3'd3:    log_byte = d[7:0];
            3'd4:    log_byte = l[15:8];
            3'd5:    log_byte = l[7:0];
            default: log_byte = r;
        endcase
    endfunction

    // Two-flop synchroniser for the asynchronous target debug GPIOs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dbg_meta <= 8'h00;
            dbg_sync <= 8'h00;
        end else begin
            dbg_meta <= debug_in;
            dbg_sync <= dbg_meta;
        end
    end

    // State, sweep position and registered (glitch-free) output pins.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= S_IDLE;
            cnt           <= 24'd0;
            cur_delay     <= DELAY_MIN;
            cur_len       <= LEN_MIN;
            attempt_count <= 16'd0;
            result        <= 8'h00;
            idx           <= 3'd0;
            log_valid     <= 1'b0;
            log_data      <= 8'h00;
            success       <= 1'b0;
            sweep_done    <= 1'b0;
            reset_out     <= 1'b0;
            glitch_out    <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            cur_delay     <= delay_n;
            cur_len       <= len_n;
            attempt_count <= attempts_n;
            result        <= result_n;
            idx           <= idx_n;
            log_valid     <= valid_n;
            log_data      <= data_n;
            success       <= success_n;
            sweep_done    <= sweep_n;
            reset_out     <= (state_n == S_RESET);
            glitch_out    <= (state_n == S_GLITCH);
            busy          <= (state_n != S_IDLE) && (state_n != S_DONE);
        end
    end

    // Next-state, phase counting, sweep stepping and log byte sequencing.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt + 24'd1;
        delay_n    = cur_delay;
        len_n      = cur_len;
        attempts_n = attempt_count;
        result_n   = result;
        idx_n      = idx;
        valid_n    = log_valid;
        data_n     = log_data;
        success_n  = success;
        sweep_n    = sweep_done;

        if (abort) begin
            // abort outranks start; in IDLE it simply keeps the FSM idle
            state_n   = S_IDLE;
            cnt_n     = 24'd0;
            valid_n   = 1'b0;
            success_n = 1'b0;
            sweep_n   = 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    cnt_n = 24'd0;
                    if (start) begin
                        state_n    = S_RESET;
                        delay_n    = DELAY_MIN;
                        len_n      = LEN_MIN;
                        attempts_n = 16'd1;
                        success_n  = 1'b0;
                        sweep_n    = 1'b0;
                    end
                end
                S_RESET: begin
                    if (cnt == RESET_LAST) begin
                        state_n = S_DELAY;
                        cnt_n   = 24'd0;
                    end
                end
                S_DELAY: begin
                    if (cnt == {8'd0, cur_delay} - 24'd1) begin
                        state_n = S_GLITCH;
                        cnt_n   = 24'd0;
                    end
                end
                S_GLITCH: begin
                    if (cnt == {8'd0, cur_len} - 24'd1) begin
                        state_n = S_WATCH;
                        cnt_n   = 24'd0;
                    end
                end
                S_WATCH: begin
                    if (code_hit || cnt == TIMEOUT_LAST) begin
                        state_n  = S_LOG;
                        cnt_n    = 24'd0;
                        idx_n    = 3'd0;
                        result_n = code_hit ? dbg_sync : 8'h00;
                    end
                end
                S_LOG: begin
                    cnt_n = 24'd0;
                    if (!log_valid) begin
                        valid_n = 1'b1;
                        data_n  = log_byte(3'd0, cur_delay, cur_len, result);
                    end else if (log_ready) begin
                        if (idx == 3'd6) begin
                            valid_n   = 1'b0;
                            state_n   = (result != 8'h00) ? S_DONE : S_ADVANCE;
                            success_n = (result != 8'h00);
                        end else begin
                            idx_n  = idx + 3'd1;
                            data_n = log_byte(idx + 3'd1, cur_delay, cur_len, result);
                        end
                    end
                end
                S_ADVANCE: begin
                    cnt_n = 24'd0;
                    if (cur_delay < DELAY_MAX) begin
                        delay_n = cur_delay + 16'd1;
                    end else if (cur_len < LEN_MAX) begin
                        delay_n = DELAY_MIN;
                        len_n   = cur_len + 16'd1;
                    end
                    if (cur_delay >= DELAY_MAX && cur_len >= LEN_MAX) begin
                        state_n = S_DONE;
                        sweep_n = 1'b1;
                    end else begin
                        state_n    = S_RESET;
                        attempts_n = (attempt_count == 16'hFFFF) ? attempt_count
                                                                 : attempt_count + 16'd1;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/glitch_sweep_sequencer.md
Name: glitch_sweep_sequencer

Overview:
Autonomous scheduler for fault-injection campaigns. It drives the target reset line and the glitch MOSFET trigger through repeated attempts, sweeping glitch delay and glitch length over a 2-D grid. After each glitch it watches the 8-bit debug GPIO port for a success code, then emits a fixed 7-byte log record on a byte stream for the UART queue. It sits between the top-level button/IO logic and the reset/glitch pin drivers, replacing ad-hoc counter logic in top.

Parameters:
RESET_CYCLES, 16'h200, cycles reset_out is held high per attempt (>=1)
DELAY_MIN, 16'h001, first glitch delay in cycles (>=1)
DELAY_MAX, 16'h300, last glitch delay (>=DELAY_MIN)
LEN_MIN, 16'h100, first glitch length in cycles (>=1)
LEN_MAX, 16'h180, last glitch length (>=LEN_MIN)
TIMEOUT_CYCLES, 24'd12_000_000, post-glitch watch window (>=1)
CODE_A, 8'h88, success debug code
CODE_B, 8'h25, success debug code

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-high reset
start  in  1  single-cycle pulse; begins sweep from (DELAY_MIN, LEN_MIN)
abort  in  1  single-cycle pulse; returns to IDLE
debug_in  in  8  raw target debug GPIOs (asynchronous)
reset_out  out  1  high = hold target in reset
glitch_out  out  1  high = fire glitch MOSFET
busy  out  1  high in any state except IDLE/DONE
success  out  1  high in DONE after a match
sweep_done  out  1  high in DONE after grid exhausted without a match
cur_delay  out  16  delay of current/last attempt
cur_len  out  16  length of current/last attempt
attempt_count  out  16  attempts started since start; saturates at 16'hFFFF
log_valid  out  1  log byte valid
log_data  out  8  log byte
log_ready  in  1  consumer accepts byte

Behaviour:
- Async reset: state IDLE; all 1-bit outputs 0; log_data 0; attempt_count 0; cur_delay=DELAY_MIN; cur_len=LEN_MIN.
- debug_in passes through a 2-flop synchroniser; matching uses only the synchronised value.
- States: IDLE, RESET, DELAY, GLITCH, WATCH, LOG, ADVANCE, DONE.
- IDLE/DONE + start: load cur_delay=DELAY_MIN, cur_len=LEN_MIN, attempt_count=1, clear success/sweep_done, go RESET. start in any other state is ignored.
- RESET: reset_out=1 for exactly RESET_CYCLES cycles, first high cycle is the cycle after start is sampled.
- DELAY: exactly cur_delay cycles with reset_out=0 and glitch_out=0.
- GLITCH: glitch_out=1 for exactly cur_len consecutive cycles; pulse is registered and glitch-free.
- WATCH: up to TIMEOUT_CYCLES cycles. If the synchronised debug equals CODE_A or CODE_B, latch result=that code and go LOG on the next cycle. On timeout, result=8'h00 and go LOG.
- LOG: send bytes 55, AA, cur_delay[15:8], cur_delay[7:0], cur_len[15:8], cur_len[7:0], result, in that order.
  - A byte transfers on a cycle where log_valid&&log_ready.
  - While log_valid&&!log_ready, log_data stays stable and log_valid stays high.
  - log_valid rises the cycle after LOG entry and drops the cycle after byte 7 transfers.
- After LOG:
  - result!=0: go DONE with success=1; cur_delay/cur_len are held.
  - result==0: go ADVANCE (1 cycle).
- ADVANCE:
  - If cur_delay<DELAY_MAX: cur_delay+1.
  - Else cur_delay=DELAY_MIN and, if cur_len<LEN_MAX, cur_len+1.
  - If delay and length were both at max: go DONE with sweep_done=1; values are held at max.
  - Otherwise: attempt_count+1 (saturating), then go RESET.
- abort (any state except IDLE): next cycle state=IDLE, reset_out=0, glitch_out=0, log_valid=0. A partial record is discarded and not resumed. abort has priority over start in the same cycle.
- Async RST mid-operation forces reset values immediately, including glitch_out=0.

Test Plan:
1. Params RESET_CYCLES=4, DELAY 2..3, LEN 1..2, TIMEOUT 8; log_ready=1; start with debug_in=0 -> reset_out high 4 cycles, 2 low cycles, glitch_out high 1 cycle, 8 watch cycles, record 55 AA 00 02 00 01 00, then next attempt uses delay 3.
2. Same params, never match -> attempts in order (2,1),(3,1),(2,2),(3,2); four records; then DONE with sweep_done=1, success=0, attempt_count=4, busy=0.
3. Drive debug_in=8'h88 from mid-WATCH of attempt 2 -> record ends 00 03 00 01 88; success=1; reset_out stays 0 afterwards; cur_delay=3.
4. Hold log_ready=0 for 5 cycles while byte 3 is pending -> log_data=00 stays stable, no byte is lost or duplicated, and all 7 bytes arrive in order.
5. abort during GLITCH -> glitch_out=0 and busy=0 on the next cycle, no LOG bytes. Separately, assert RST mid-LOG -> all outputs are at reset values without waiting for a clock edge.
6. Pulse start during WATCH -> ignored; attempt_count is unchanged and the sweep continues normally.
